spi_obi_bridge: RTL and testbench
=================================

// Module: spi_obi_bridge
// PURPOSE
//  SPI target (slave) that lets an external SPI host read/write words on the SoC bus.
//  It is the responder end of the SPI link; the SoC's SPI flash controller is the initiator end.
//  Decoded SPI frames become single-word bus-initiator transactions (req/gnt/rvalid) into the SoC multiplexer.
//  SPI pins are oversampled in the clk_i domain. SCK must be <= clk_i/8.
// PARAMETERS
//  SYNC_STAGES  2             flip-flop stages on sck/cs_n/sdi synchronisers (>=2)
//  DUMMY_BITS   8             turnaround bits between read address and read data (multiple of 1, >=8)
//  ID_CODE      32'h5E71_0001 word returned by the ID command
// PORTS
//  clk_i         in   1   system clock
//  rst_ni        in   1   reset, asynchronous, active-low
//  spi_sck_i     in   1   SPI clock from host, mode 0 (CPOL=0, CPHA=0)
//  spi_cs_ni     in   1   SPI chip select, active-low
//  spi_sdi_i     in   1   host->target data, MSB first
//  spi_sdo_o     out  1   target->host data, MSB first
//  spi_sdo_oe_o  out  1   output enable for sdo pad (1 while synced cs_n low)
//  obi_req_o     out  1   bus request
//  obi_gnt_i     in   1   bus grant
//  obi_rvalid_i  in   1   bus response valid (reads and writes)
//  obi_addr_o    out  32  word address, [1:0] forced 0
//  obi_we_o      out  1   1=write
//  obi_be_o      out  4   byte enables, always 4'hF while req
//  obi_wdata_o   out  32  write data
//  obi_rdata_i   in   32  read data, valid with rvalid
// BEHAVIOUR
//  Reset: all outputs 0; both FSMs idle; status flags 0. Reset mid-transaction drops obi_req_o immediately. No replay.
//  Sync: sck, cs_n and sdi each pass SYNC_STAGES FFs. Rise/fall detection uses the synced sck vs its previous value.
//  sdi sampled on sck rise; sdo updated on sck fall. First sdo bit of a field is set up in the cycle the field begins.
//  Frame FSM: IDLE -> CMD(8b) -> ADDR(32b) -> WDATA(32b) | DUMMY(DUMMY_BITS) -> RDATA(32b) -> DONE; IGNORE for bad cmd.
//   0x02 write: CMD, ADDR, WDATA. The bus write is posted after the 32nd data bit.
//   0x03 read: CMD, ADDR, DUMMY, RDATA. The bus read is posted after the 32nd address bit.
//   0x05 status: CMD then 8 bits out = {6'b0, late, bus_busy}. It clears late at the end of byte.
//   0x9F id: CMD then ID_CODE out (32b). Any other cmd -> IGNORE until cs_n high, sdo=0, no bus op.
//   Extra sck edges after a field completes (DONE) are ignored and sdo=0.
//  cs_n rising at any point: frame FSM -> IDLE, shift counters cleared, partial fields discarded.
//   A bus op already posted still completes; an op not yet posted is never issued.
//  Bus FSM: B_IDLE -> B_REQ (req=1, addr/we/be/wdata stable) -> on gnt -> B_RESP (req=0) -> on rvalid -> B_IDLE.
//   obi_req_o rises the clk_i cycle after the post event. gnt in the same cycle as req rise is legal.
//   gnt and rvalid in the same cycle is not expected; rvalid counts only in B_RESP.
//   Read data is latched on rvalid into the read shift register.
//   One pending slot: a post while the bus is busy is held and launched the cycle after B_IDLE is reached.
//   A second post while a slot is pending overwrites the slot and sets late.
//  Late read: rvalid not yet received when the first RDATA bit must be driven -> shift out 32'hFFFF_FFFF and set late.
//   A later rvalid for that read is consumed and discarded.
//  bus_busy = bus FSM not in B_IDLE or slot pending.
//  Address/data field bits are assembled MSB first into 32-bit words. No endianness swap.
// TESTING
//  cmd 0x02, addr 0x0000_0010, data 0xCAFE_BABE; gnt same cycle, rvalid +1 -> exactly one req: we=1, be=F, addr=0x10, wdata=CAFEBABE.
//  cmd 0x03, addr 0x0000_0013, gnt after 3 cycles, rvalid=0x1234_5678 -> addr=0x10, we=0; host shifts in 0x12345678.
//  cmd 0x03 with gnt delayed past dummy phase -> host reads 0xFFFFFFFF; then cmd 0x05 -> 0x02; second 0x05 -> 0x00.
//  cs_n high after 20 address bits of 0x02 -> no req. A following 0x9F frame returns 0x5E710001.
//  cmd 0xAB with 40 trailing clocks -> sdo stays 0, no req. Then 0x03 read works normally.
//  rst_ni low while obi_req_o=1 -> req=0 asynchronously; after release the 0x05 status read returns 0x00.

Source files
------------

// File: rtl/spi_obi_bridge.sv
// SPI mode-0 target that turns host frames into single-word OBI bus transactions.
// The SPI pins are oversampled in the clk_i domain, so SCK must stay at or below clk_i/8.
`timescale 1ns/1ps
module spi_obi_bridge #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DUMMY_BITS  = 8,
    parameter logic [31:0] ID_CODE     = 32'h5E71_0001
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        spi_sck_i,
    input  logic        spi_cs_ni,
    input  logic        spi_sdi_i,
    output logic        spi_sdo_o,
    output logic        spi_sdo_oe_o,
    output logic        obi_req_o,
    input  logic        obi_gnt_i,
    input  logic        obi_rvalid_i,
    output logic [31:0] obi_addr_o,
    output logic        obi_we_o,
    output logic [3:0]  obi_be_o,
    output logic [31:0] obi_wdata_o,
    input  logic [31:0] obi_rdata_i
);
    localparam int unsigned MAX_BITS = (DUMMY_BITS > 32) ? DUMMY_BITS : 32;
    localparam int unsigned CNT_W    = $clog2(MAX_BITS + 1);

    typedef enum logic [3:0] {
        F_IDLE, F_CMD, F_ADDR_WR, F_ADDR_RD, F_WDATA, F_DUMMY,
        F_RDATA, F_STATUS, F_ID, F_DONE, F_IGNORE
    } frame_state_e;
    typedef enum logic [1:0] {B_IDLE, B_REQ, B_RESP} bus_state_e;

    logic [SYNC_STAGES-1:0] sck_sync_reg, cs_sync_reg, sdi_sync_reg;
    logic                   sck_prev_reg;
    frame_state_e           f_state_reg, f_state_next;
    bus_state_e             b_state_reg, b_state_next;
    logic [CNT_W-1:0]       bit_cnt_reg;
    logic [31:0]            rx_reg, tx_reg, rdata_reg;
    logic [31:2]            addr_reg, bus_addr_reg, slot_addr_reg;
    logic [31:0]            bus_wdata_reg, slot_wdata_reg;
    logic                   bus_we_reg, slot_we_reg, slot_valid_reg;
    logic                   bus_live_reg, slot_live_reg, rdata_ok_reg, late_reg;

    logic        sck_s, cs_s, sdi_s, sck_rise, sck_fall;
    logic [31:0] rx_word, tx_val;
    logic        cnt_clr, cnt_inc, tx_load, addr_save, post_wr, post_rd;
    logic        rd_late, rd_drop, clr_late, post, launch_slot, launch_post, bus_busy;
    logic        set_late, out_field;
    logic [31:2] post_addr;

    assign sck_s     = sck_sync_reg[SYNC_STAGES-1];
    assign cs_s      = cs_sync_reg[SYNC_STAGES-1];
    assign sdi_s     = sdi_sync_reg[SYNC_STAGES-1];
    assign sck_rise  = sck_s & ~sck_prev_reg;
    assign sck_fall  = ~sck_s & sck_prev_reg;
    assign rx_word   = {rx_reg[30:0], sdi_s};
    assign post      = post_wr | post_rd;
    assign post_addr = post_rd ? rx_word[31:2] : addr_reg;
    assign bus_busy  = (b_state_reg != B_IDLE) | slot_valid_reg;
    assign out_field = (f_state_reg == F_RDATA) | (f_state_reg == F_ID) | (f_state_reg == F_STATUS);
    // A post that neither launches nor lands in an empty slot overwrites a pending one.
    assign set_late  = rd_late | (post & ~launch_post & slot_valid_reg & ~launch_slot);

    assign spi_sdo_o    = tx_reg[31];
    assign spi_sdo_oe_o = ~cs_s;
    assign obi_req_o    = (b_state_reg == B_REQ);
    assign obi_be_o     = obi_req_o ? 4'hF : 4'h0;
    assign obi_addr_o   = {bus_addr_reg, 2'b00};
    assign obi_we_o     = bus_we_reg;
    assign obi_wdata_o  = bus_wdata_reg;

    always_comb begin
        f_state_next = f_state_reg;
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;
        tx_load   = 1'b0;
        tx_val    = '0;
        addr_save = 1'b0;
        post_wr   = 1'b0;
        post_rd   = 1'b0;
        rd_late   = 1'b0;
        rd_drop   = 1'b0;
        clr_late  = 1'b0;
        if (cs_s) begin
            f_state_next = F_IDLE;
            cnt_clr      = 1'b1;
            tx_load      = 1'b1;
        end else if (f_state_reg == F_IDLE) begin
            f_state_next = F_CMD;
            cnt_clr      = 1'b1;
        end else if (sck_rise) begin
            cnt_inc = 1'b1;
            case (f_state_reg)
                F_CMD: if (bit_cnt_reg == CNT_W'(7)) begin
                    cnt_clr = 1'b1;
                    tx_load = 1'b1;
                    case (rx_word[7:0])
                        8'h02: f_state_next = F_ADDR_WR;
                        8'h03: f_state_next = F_ADDR_RD;
                        8'h05: begin
                            f_state_next = F_STATUS;
                            tx_val = {6'b0, late_reg, bus_busy, 24'h0};
                        end
                        8'h9F: begin
                            f_state_next = F_ID;
                            tx_val = ID_CODE;
                        end
                        default: f_state_next = F_IGNORE;
                    endcase
                end
                F_ADDR_WR: if (bit_cnt_reg == CNT_W'(31)) begin
                    cnt_clr      = 1'b1;
                    addr_save    = 1'b1;
                    f_state_next = F_WDATA;
                end
                F_ADDR_RD: if (bit_cnt_reg == CNT_W'(31)) begin
                    cnt_clr      = 1'b1;
                    post_rd      = 1'b1;
                    f_state_next = F_DUMMY;
                end
                F_WDATA: if (bit_cnt_reg == CNT_W'(31)) begin
                    cnt_clr      = 1'b1;
                    post_wr      = 1'b1;
                    f_state_next = F_DONE;
                end
                F_DUMMY: if (bit_cnt_reg == CNT_W'(DUMMY_BITS - 1)) begin
                    cnt_clr      = 1'b1;
                    tx_load      = 1'b1;
                    rd_drop      = 1'b1;
                    f_state_next = F_RDATA;
                    if (rdata_ok_reg) begin
                        tx_val = rdata_reg;
                    end else begin
                        tx_val  = '1;
                        rd_late = 1'b1;
                    end
                end
                F_RDATA, F_ID: if (bit_cnt_reg == CNT_W'(31)) begin
                    cnt_clr      = 1'b1;
                    tx_load      = 1'b1;
                    f_state_next = F_DONE;
                end
                F_STATUS: if (bit_cnt_reg == CNT_W'(7)) begin
                    cnt_clr      = 1'b1;
                    tx_load      = 1'b1;
                    clr_late     = 1'b1;
                    f_state_next = F_DONE;
                end
                default: cnt_inc = 1'b0;
            endcase
        end
    end

    always_comb begin
        b_state_next = b_state_reg;
        launch_slot  = 1'b0;
        launch_post  = 1'b0;
        case (b_state_reg)
            B_IDLE: begin
                if (slot_valid_reg) begin
                    launch_slot  = 1'b1;
                    b_state_next = B_REQ;
                end else if (post) begin
                    launch_post  = 1'b1;
                    b_state_next = B_REQ;
                end
            end
            B_REQ:   if (obi_gnt_i) b_state_next = B_RESP;
            B_RESP:  if (obi_rvalid_i) b_state_next = B_IDLE;
            default: b_state_next = B_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sck_sync_reg <= '0;
            cs_sync_reg  <= '1;
            sdi_sync_reg <= '0;
            sck_prev_reg <= 1'b0;
            f_state_reg  <= F_IDLE;
            bit_cnt_reg  <= '0;
            rx_reg       <= '0;
            tx_reg       <= '0;
            addr_reg     <= '0;
            late_reg     <= 1'b0;
        end else begin
            sck_sync_reg <= {sck_sync_reg[SYNC_STAGES-2:0], spi_sck_i};
            cs_sync_reg  <= {cs_sync_reg[SYNC_STAGES-2:0], spi_cs_ni};
            sdi_sync_reg <= {sdi_sync_reg[SYNC_STAGES-2:0], spi_sdi_i};
            sck_prev_reg <= sck_s;
            f_state_reg  <= f_state_next;
            if (cnt_clr)      bit_cnt_reg <= '0;
            else if (cnt_inc) bit_cnt_reg <= bit_cnt_reg + CNT_W'(1);
            if (sck_rise && !cs_s) rx_reg <= rx_word;
            // The first bit of an output field is already on sdo; shift only after it was sampled.
            if (tx_load)                                     tx_reg <= tx_val;
            else if (sck_fall && out_field && bit_cnt_reg != '0) tx_reg <= {tx_reg[30:0], 1'b0};
            if (addr_save) addr_reg <= rx_word[31:2];
            if (set_late)      late_reg <= 1'b1;
            else if (clr_late) late_reg <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            b_state_reg    <= B_IDLE;
            bus_addr_reg   <= '0;
            bus_we_reg     <= 1'b0;
            bus_wdata_reg  <= '0;
            slot_addr_reg  <= '0;
            slot_we_reg    <= 1'b0;
            slot_wdata_reg <= '0;
            slot_valid_reg <= 1'b0;
            bus_live_reg   <= 1'b0;
            slot_live_reg  <= 1'b0;
            rdata_reg      <= '0;
            rdata_ok_reg   <= 1'b0;
        end else begin
            b_state_reg <= b_state_next;
            if (launch_slot) begin
                bus_addr_reg  <= slot_addr_reg;
                bus_we_reg    <= slot_we_reg;
                bus_wdata_reg <= slot_wdata_reg;
            end else if (launch_post) begin
                bus_addr_reg  <= post_addr;
                bus_we_reg    <= post_wr;
                bus_wdata_reg <= post_wr ? rx_word : 32'h0;
            end
            if (post && !launch_post) begin
                slot_valid_reg <= 1'b1;
                slot_addr_reg  <= post_addr;
                slot_we_reg    <= post_wr;
                slot_wdata_reg <= post_wr ? rx_word : 32'h0;
                slot_live_reg  <= post_rd;
            end else if (launch_slot) begin
                slot_valid_reg <= 1'b0;
            end
            // Only the read belonging to the current frame may deliver data; stale responses are dropped.
            if (b_state_reg == B_RESP && obi_rvalid_i) begin
                bus_live_reg <= 1'b0;
                if (bus_live_reg) begin
                    rdata_reg    <= obi_rdata_i;
                    rdata_ok_reg <= 1'b1;
                end
            end
            if (launch_slot)      bus_live_reg <= slot_live_reg;
            else if (launch_post) bus_live_reg <= post_rd;
            if (post_rd) begin
                rdata_ok_reg <= 1'b0;
                if (!launch_post) bus_live_reg <= 1'b0;
            end
            if (rd_drop) begin
                bus_live_reg  <= 1'b0;
                slot_live_reg <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_spi_obi_bridge.sv
// Scoreboard bench: stimulus queues expected bus requests and host read words; a monitor compares them.
`timescale 1ns/1ps
module tb_spi_obi_bridge;
    localparam int HALF  = 6;
    localparam int DUMMY = 8;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        sck = 1'b0, cs_n = 1'b1, sdi = 1'b0;
    logic        sdo, sdo_oe, req, we;
    logic        gnt = 1'b0, rvalid = 1'b0;
    logic [31:0] addr, wdata, rdata = 32'h0;
    logic [3:0]  be;

    always #5 clk = ~clk;

    spi_obi_bridge #(.SYNC_STAGES(2), .DUMMY_BITS(DUMMY), .ID_CODE(32'h5E71_0001)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .spi_sck_i(sck), .spi_cs_ni(cs_n), .spi_sdi_i(sdi),
        .spi_sdo_o(sdo), .spi_sdo_oe_o(sdo_oe),
        .obi_req_o(req), .obi_gnt_i(gnt), .obi_rvalid_i(rvalid),
        .obi_addr_o(addr), .obi_we_o(we), .obi_be_o(be),
        .obi_wdata_o(wdata), .obi_rdata_i(rdata)
    );

    typedef struct { logic [31:0] addr; logic we; logic [31:0] wdata; } bus_exp_t;
    typedef struct { logic [63:0] val; string name; } rd_exp_t;

    bus_exp_t    exp_bus_q[$];
    rd_exp_t     exp_rd_q[$];
    logic [63:0] obs_rd_q[$];
    bus_exp_t    mon_b;
    rd_exp_t     mon_r;
    logic [63:0] mon_o;
    int          tests_run = 0, tests_failed = 0;
    bit          hold = 1'b0;
    int          gnt_delay = 0, wait_cnt = 0;
    logic [31:0] rsp_rdata = 32'h0;
    logic [63:0] got;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        tests_run++;
        if (act !== exp_v) begin
            tests_failed++;
            $display("FAIL %s: got %h, expected %h", name, act, exp_v);
        end else begin
            $display("[TB] ok %s: %h", name, act);
        end
    endtask

    // Bus responder: gnt after gnt_delay cycles of req (unless held), rvalid the cycle after gnt.
    initial begin
        forever begin
            @(posedge clk); #1;
            rvalid = 1'b0;
            if (!rst_n) begin
                gnt = 1'b0;
                wait_cnt = 0;
            end else if (gnt) begin
                gnt    = 1'b0;
                rvalid = 1'b1;
                rdata  = rsp_rdata;
            end else if (req && !hold) begin
                if (wait_cnt >= gnt_delay) begin
                    gnt = 1'b1;
                    wait_cnt = 0;
                end else begin
                    wait_cnt++;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && req && gnt) begin
            if (exp_bus_q.size() == 0) begin
                tests_run++;
                tests_failed++;
                $display("FAIL bus_unexpected_req: got addr=%h we=%b, expected no request", addr, we);
            end else begin
                mon_b = exp_bus_q.pop_front();
                check("bus_addr", {32'h0, addr}, {32'h0, mon_b.addr});
                check("bus_we", {63'h0, we}, {63'h0, mon_b.we});
                check("bus_be", {60'h0, be}, 64'hF);
                if (mon_b.we) check("bus_wdata", {32'h0, wdata}, {32'h0, mon_b.wdata});
            end
        end
        if (obs_rd_q.size() != 0) begin
            mon_o = obs_rd_q.pop_front();
            if (exp_rd_q.size() == 0) begin
                tests_run++;
                tests_failed++;
                $display("FAIL spi_unexpected_read: got %h, expected nothing", mon_o);
            end else begin
                mon_r = exp_rd_q.pop_front();
                check(mon_r.name, mon_o, mon_r.val);
            end
        end
    end

    task automatic spi_bits(input logic [63:0] dout, input int n, output logic [63:0] din);
        din = '0;
        for (int i = n - 1; i >= 0; i--) begin
            sdi = dout[i];
            repeat (HALF) @(posedge clk);
            #2;
            din = {din[62:0], sdo};
            sck = 1'b1;
            repeat (HALF) @(posedge clk);
            #2;
            sck = 1'b0;
        end
    endtask

    task automatic cs_begin();
        cs_n = 1'b0;
        repeat (HALF) @(posedge clk);
        #2;
        check("sdo_oe_active", {63'h0, sdo_oe}, 64'h1);
    endtask

    task automatic cs_end();
        repeat (HALF) @(posedge clk);
        cs_n = 1'b1;
        repeat (3 * HALF) @(posedge clk);
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d);
        logic [63:0] dummy;
        cs_begin();
        spi_bits(64'h02, 8, dummy);
        spi_bits({32'h0, a}, 32, dummy);
        spi_bits({32'h0, d}, 32, dummy);
        cs_end();
    endtask

    task automatic do_read(input logic [31:0] a);
        logic [63:0] dummy, din;
        cs_begin();
        spi_bits(64'h03, 8, dummy);
        spi_bits({32'h0, a}, 32, dummy);
        spi_bits(64'h0, DUMMY, dummy);
        spi_bits(64'h0, 32, din);
        cs_end();
        obs_rd_q.push_back(din);
    endtask

    task automatic do_short(input logic [7:0] cmd, input int n);
        logic [63:0] dummy, din;
        cs_begin();
        spi_bits({56'h0, cmd}, 8, dummy);
        spi_bits(64'h0, n, din);
        cs_end();
        obs_rd_q.push_back(din);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (5) @(posedge clk);
        #1;
        check("rst_req", {63'h0, req}, 64'h0);
        check("rst_sdo_oe", {63'h0, sdo_oe}, 64'h0);
        check("rst_sdo", {63'h0, sdo}, 64'h0);
        check("rst_addr_wdata", {addr, wdata}, 64'h0);
        check("rst_we_be", {59'h0, we, be}, 64'h0);
        @(negedge clk) rst_n = 1'b1;
        repeat (5) @(posedge clk);

        gnt_delay = 0;
        exp_bus_q.push_back('{addr: 32'h10, we: 1'b1, wdata: 32'hCAFE_BABE});
        do_write(32'h0000_0010, 32'hCAFE_BABE);

        gnt_delay = 3;
        rsp_rdata = 32'h1234_5678;
        exp_bus_q.push_back('{addr: 32'h10, we: 1'b0, wdata: 32'h0});
        exp_rd_q.push_back('{val: 64'h1234_5678, name: "read_0x13"});
        do_read(32'h0000_0013);

        hold = 1'b1;
        rsp_rdata = 32'hDEAD_BEEF;
        exp_bus_q.push_back('{addr: 32'h20, we: 1'b0, wdata: 32'h0});
        exp_rd_q.push_back('{val: 64'hFFFF_FFFF, name: "late_read"});
        do_read(32'h0000_0020);
        hold = 1'b0;
        repeat (20) @(posedge clk);
        exp_rd_q.push_back('{val: 64'h02, name: "status_late"});
        do_short(8'h05, 8);
        exp_rd_q.push_back('{val: 64'h00, name: "status_cleared"});
        do_short(8'h05, 8);

        cs_begin();
        spi_bits(64'h02, 8, got);
        spi_bits(64'hABCDE, 20, got);
        cs_end();
        exp_rd_q.push_back('{val: 64'h5E71_0001, name: "id_code"});
        do_short(8'h9F, 32);

        exp_rd_q.push_back('{val: 64'h0, name: "ignore_sdo"});
        do_short(8'hAB, 40);
        gnt_delay = 1;
        rsp_rdata = 32'hA5A5_5A5A;
        exp_bus_q.push_back('{addr: 32'h44, we: 1'b0, wdata: 32'h0});
        exp_rd_q.push_back('{val: 64'hA5A5_5A5A, name: "read_after_ignore"});
        do_read(32'h0000_0044);

        hold = 1'b1;
        do_write(32'h0000_0080, 32'h0000_0011);
        for (int i = 0; i < 200 && !req; i++) @(posedge clk);
        check("req_before_reset", {63'h0, req}, 64'h1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("req_async_reset", {63'h0, req}, 64'h0);
        check("be_async_reset", {60'h0, be}, 64'h0);
        repeat (3) @(posedge clk);
        hold = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        repeat (5) @(posedge clk);
        exp_rd_q.push_back('{val: 64'h00, name: "status_after_reset"});
        do_short(8'h05, 8);

        repeat (20) @(posedge clk);
        check("bus_expect_left", 64'(exp_bus_q.size()), 64'h0);
        check("read_expect_left", 64'(exp_rd_q.size()), 64'h0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
